// File: rtl/chorus_tap_scheduler.sv
// Chorus tap scheduler: shares one single-port stereo delay RAM across NUM_TAPS modulated taps.
// Define CHORUS_DRY_MIX_EN to emit a 50/50 mix of the latched dry input and the wet average.
module chorus_tap_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_TAPS   = 4,
    parameter int unsigned OFFS_WIDTH = 9,
    parameter int unsigned BASE_DELAY = 480
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sample_tick,
    input  logic [DATA_WIDTH-1:0]          audio_right_in,
    input  logic [DATA_WIDTH-1:0]          audio_left_in,
    input  logic [NUM_TAPS*OFFS_WIDTH-1:0] tap_offsets,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_we,
    output logic [2*DATA_WIDTH-1:0]        mem_wdata,
    input  logic [2*DATA_WIDTH-1:0]        mem_rdata,
    output logic [DATA_WIDTH-1:0]          audio_right_out,
    output logic [DATA_WIDTH-1:0]          audio_left_out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int unsigned TapW = $clog2(NUM_TAPS);
    localparam int unsigned AccW = DATA_WIDTH + TapW;
    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_DELAY);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StOutput} state_e;

    state_e                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic [TapW-1:0]               tap_q, tap_d;
    logic [NUM_TAPS*OFFS_WIDTH-1:0] offs_q, offs_d;
    logic signed [AccW-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic                          rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0]         mem_addr_q, mem_addr_d;
    logic                          mem_we_q, mem_we_d;
    logic [2*DATA_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0]         out_l_q, out_l_d, out_r_q, out_r_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;

    logic [OFFS_WIDTH-1:0]         offs_arr [NUM_TAPS];
    logic [TapW-1:0]               tap_nxt;
    logic [ADDR_WIDTH-1:0]         tap_addr;
    logic [DATA_WIDTH-1:0]         rd_l, rd_r;
    logic signed [DATA_WIDTH-1:0]  wet_l, wet_r;

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_offs
        assign offs_arr[g] = offs_q[g*OFFS_WIDTH +: OFFS_WIDTH];
    end

    assign rd_l = mem_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign rd_r = mem_rdata[DATA_WIDTH-1:0];

`ifdef CHORUS_DRY_MIX_EN
    logic [DATA_WIDTH-1:0]        dry_l, dry_r;
    logic signed [DATA_WIDTH:0]   mix_l, mix_r;
    // The written word still holds the dry sample of the sequence in flight.
    assign dry_l = mem_wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign dry_r = mem_wdata_q[DATA_WIDTH-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_addr_d   = wr_addr_q;
        tap_d       = tap_q;
        offs_d      = offs_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        rd_valid_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        // Read data lags its address by one cycle.
        if (rd_valid_q) begin
            acc_l_d = acc_l_q + {{TapW{rd_l[DATA_WIDTH-1]}}, rd_l};
            acc_r_d = acc_r_q + {{TapW{rd_r[DATA_WIDTH-1]}}, rd_r};
        end

        tap_nxt  = (state_q == StWrite) ? '0 : tap_q + 1'b1;
        tap_addr = wr_addr_q - BaseAddr - ADDR_WIDTH'(offs_arr[tap_nxt]);
        wet_l    = DATA_WIDTH'(acc_l_d >>> TapW);
        wet_r    = DATA_WIDTH'(acc_r_d >>> TapW);
`ifdef CHORUS_DRY_MIX_EN
        mix_l    = {dry_l[DATA_WIDTH-1], dry_l} + {wet_l[DATA_WIDTH-1], wet_l};
        mix_r    = {dry_r[DATA_WIDTH-1], dry_r} + {wet_r[DATA_WIDTH-1], wet_r};
`endif

        unique case (state_q)
            StIdle: begin
                if (sample_tick) begin
                    offs_d      = tap_offsets;
                    wr_addr_d   = wr_ptr_q;
                    mem_addr_d  = wr_ptr_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = {audio_left_in, audio_right_in};
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                acc_l_d    = '0;
                acc_r_d    = '0;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                tap_d      = '0;
                mem_addr_d = tap_addr;
                state_d    = StRead;
            end
            StRead: begin
                rd_valid_d = 1'b1;
                if (tap_q == TapW'(NUM_TAPS - 1)) begin
                    state_d = StDrain;
                end else begin
                    tap_d      = tap_nxt;
                    mem_addr_d = tap_addr;
                end
            end
            StDrain: begin
`ifdef CHORUS_DRY_MIX_EN
                out_l_d = DATA_WIDTH'(mix_l >>> 1);
                out_r_d = DATA_WIDTH'(mix_r >>> 1);
`else
                out_l_d = wet_l;
                out_r_d = wet_r;
`endif
                out_valid_d = 1'b1;
                state_d     = StOutput;
            end
            StOutput: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (sample_tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            wr_addr_q   <= '0;
            tap_q       <= '0;
            offs_q      <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            rd_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_addr_q   <= wr_addr_d;
            tap_q       <= tap_d;
            offs_q      <= offs_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            rd_valid_q  <= rd_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_addr        = mem_addr_q;
    assign mem_we          = mem_we_q;
    assign mem_wdata       = mem_wdata_q;
    assign audio_left_out  = out_l_q;
    assign audio_right_out = out_r_q;
    assign out_valid       = out_valid_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_chorus_tap_scheduler.sv
// Directed bench for chorus_tap_scheduler with a registered-read single-port RAM model.
module tb_chorus_tap_scheduler;
    localparam bit DryMix =
`ifdef CHORUS_DRY_MIX_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk, rst, sample_tick;
    logic [15:0] audio_right_in, audio_left_in;
    logic [35:0] tap_offsets;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] audio_right_out, audio_left_out;
    logic        out_valid, busy, overrun;

    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] ram [0:4095];

    logic        obs_we    [1:12];
    logic [11:0] obs_addr  [1:12];
    logic [31:0] obs_wdata [1:12];
    logic        obs_valid [1:12];
    logic        obs_busy  [1:12];
    logic [15:0] obs_l     [1:12];
    logic [15:0] obs_r     [1:12];

    int n_cmp  = 0;
    int n_fail = 0;

    chorus_tap_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .sample_tick    (sample_tick),
        .audio_right_in (audio_right_in),
        .audio_left_in  (audio_left_in),
        .tap_offsets    (tap_offsets),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .audio_right_out(audio_right_out),
        .audio_left_out (audio_left_out),
        .out_valid      (out_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [15:0] mixed(input int dry, input int wet);
        return DryMix ? 16'((dry + wet) >>> 1) : 16'(wet);
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Tick at the next edge, then record cycles T+1..T+12 at mid-cycle.
    task automatic do_tick(input logic [15:0] l, input logic [15:0] r, input logic [35:0] offs);
        @(negedge clk);
        audio_left_in  = l;
        audio_right_in = r;
        tap_offsets    = offs;
        sample_tick    = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            obs_we[k]    = mem_we;
            obs_addr[k]  = mem_addr;
            obs_wdata[k] = mem_wdata;
            obs_valid[k] = out_valid;
            obs_busy[k]  = busy;
            obs_l[k]     = audio_left_out;
            obs_r[k]     = audio_right_out;
            if (k == 1) begin
                sample_tick    = 1'b0;
                tap_offsets    = ~offs;
                audio_left_in  = ~l;
                audio_right_in = ~r;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if ({mem_we, mem_addr, mem_wdata} !== 45'd0) begin
            $display("FAIL reset_mem: got we=%0b addr=%0d wdata=%h want 0", mem_we, mem_addr,
                     mem_wdata);
            n_fail++;
        end
        n_cmp++;
        if ({audio_left_out, audio_right_out, out_valid, busy, overrun} !== 35'd0) begin
            $display("FAIL reset_out: got L=%h R=%h v=%0b b=%0b o=%0b want 0", audio_left_out,
                     audio_right_out, out_valid, busy, overrun);
            n_fail++;
        end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_first_tick();
        preload(12'd3616, {16'd400, 16'hFFF8});
        do_tick(16'd100, 16'hFF9C, 36'd0);
        if ({obs_we[1], obs_addr[1], obs_wdata[1]} !== {1'b1, 12'd0, 32'h0064_FF9C}) begin
            $display("FAIL first_write: got we=%0b addr=%0d wdata=%h want 1/0/0064ff9c",
                     obs_we[1], obs_addr[1], obs_wdata[1]);
            n_fail++;
        end
        n_cmp++;
        for (int k = 2; k <= 5; k++) begin
            if ({obs_we[k], obs_addr[k]} !== {1'b0, 12'd3616}) begin
                $display("FAIL first_read%0d: got we=%0b addr=%0d want 0/3616", k - 2, obs_we[k],
                         obs_addr[k]);
                n_fail++;
            end
            n_cmp++;
        end
        for (int k = 1; k <= 12; k++) begin
            if (obs_valid[k] !== (k == 7)) begin
                $display("FAIL first_valid_T+%0d: got %0b want %0b", k, obs_valid[k], k == 7);
                n_fail++;
            end
            n_cmp++;
        end
        if ({obs_l[7], obs_r[7]} !== {mixed(100, 400), mixed(-100, -8)}) begin
            $display("FAIL first_out: got L=%0d R=%0d want L=%0d R=%0d", $signed(obs_l[7]),
                     $signed(obs_r[7]), $signed(mixed(100, 400)), $signed(mixed(-100, -8)));
            n_fail++;
        end
        n_cmp++;
        if ({obs_busy[1], obs_busy[7], obs_busy[8]} !== 3'b110) begin
            $display("FAIL first_busy: got T1=%0b T7=%0b T8=%0b want 1/1/0", obs_busy[1],
                     obs_busy[7], obs_busy[8]);
            n_fail++;
        end
        n_cmp++;
        do_tick(16'd0, 16'd0, 36'd0);
        if ({obs_addr[1], obs_addr[2]} !== {12'd1, 12'd3617}) begin
            $display("FAIL second_write: got wr=%0d tap0=%0d want 1/3617", obs_addr[1],
                     obs_addr[2]);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_offsets();
        apply_reset();
        preload(12'd3616, 32'h0004_FFFF);
        preload(12'd3615, 32'h0008_FFFF);
        preload(12'd3614, 32'h000C_FFFF);
        preload(12'd3613, 32'hFFFD_FFFE);
        do_tick(16'd7, 16'hFFF7, {9'd3, 9'd2, 9'd1, 9'd0});
        for (int k = 2; k <= 5; k++) begin
            if (obs_addr[k] !== 12'(3616 - (k - 2))) begin
                $display("FAIL offs_addr%0d: got %0d want %0d", k - 2, obs_addr[k],
                         3616 - (k - 2));
                n_fail++;
            end
            n_cmp++;
        end
        if ({obs_l[7], obs_r[7]} !== {mixed(7, 5), mixed(-9, -2)}) begin
            $display("FAIL offs_out: got L=%0d R=%0d want L=%0d R=%0d", $signed(obs_l[7]),
                     $signed(obs_r[7]), $signed(mixed(7, 5)), $signed(mixed(-9, -2)));
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_overrun();
        int nv, nw;
        logic o3, o4;
        nv = 0;
        nw = 0;
        o3 = 1'b0;
        o4 = 1'b0;
        if (overrun !== 1'b0) begin
            $display("FAIL overrun_pre: got %0b want 0", overrun);
            n_fail++;
        end
        n_cmp++;
        @(negedge clk);
        tap_offsets = 36'd0;
        sample_tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            nv += int'(out_valid);
            nw += int'(mem_we);
            obs_busy[k] = busy;
            if (k == 3) o3 = overrun;
            if (k == 4) o4 = overrun;
            sample_tick = (k == 3);
        end
        if ({o3, o4, overrun} !== 3'b011) begin
            $display("FAIL overrun_flag: got T3=%0b T4=%0b T12=%0b want 0/1/1", o3, o4, overrun);
            n_fail++;
        end
        n_cmp++;
        if (nv !== 1 || nw !== 1) begin
            $display("FAIL overrun_single: got valids=%0d writes=%0d want 1/1", nv, nw);
            n_fail++;
        end
        n_cmp++;
        if (obs_busy[8] !== 1'b0) begin
            $display("FAIL overrun_busy: got %0b want 0", obs_busy[8]);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid_read();
        int nv;
        nv = 0;
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        if ({mem_we, mem_addr, mem_wdata, out_valid, busy, overrun} !== 48'd0) begin
            $display("FAIL rst_mid_bus: got we=%0b addr=%0d wd=%h v=%0b b=%0b o=%0b want 0",
                     mem_we, mem_addr, mem_wdata, out_valid, busy, overrun);
            n_fail++;
        end
        n_cmp++;
        if ({audio_left_out, audio_right_out} !== 32'd0) begin
            $display("FAIL rst_mid_out: got L=%h R=%h want 0", audio_left_out, audio_right_out);
            n_fail++;
        end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nv += int'(out_valid);
        end
        if (nv !== 0) begin
            $display("FAIL rst_mid_novalid: got %0d pulses want 0", nv);
            n_fail++;
        end
        n_cmp++;
        do_tick(16'd5, 16'd6, 36'd0);
        if ({obs_we[1], obs_addr[1]} !== {1'b1, 12'd0}) begin
            $display("FAIL rst_mid_wrptr: got we=%0b addr=%0d want 1/0", obs_we[1], obs_addr[1]);
            n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_wrap();
        logic [11:0] exp_a [2:5];
        apply_reset();
        tap_offsets = 36'd0;
        for (int i = 0; i < 4095; i++) begin
            @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
            repeat (7) @(negedge clk);
        end
        do_tick(16'd1, 16'd2, {9'd3, 9'd2, 9'd1, 9'd0});
        if (obs_addr[1] !== 12'd4095) begin
            $display("FAIL wrap_write_top: got %0d want 4095", obs_addr[1]);
            n_fail++;
        end
        n_cmp++;
        for (int k = 2; k <= 5; k++) begin
            if (obs_addr[k] !== 12'(3615 - (k - 2))) begin
                $display("FAIL wrap_top_tap%0d: got %0d want %0d", k - 2, obs_addr[k],
                         3615 - (k - 2));
                n_fail++;
            end
            n_cmp++;
        end
        do_tick(16'd1, 16'd2, {9'd10, 9'd0, 9'd511, 9'd5});
        if (obs_addr[1] !== 12'd0) begin
            $display("FAIL wrap_write_zero: got %0d want 0", obs_addr[1]);
            n_fail++;
        end
        n_cmp++;
        exp_a[2] = 12'd3611;
        exp_a[3] = 12'd3105;
        exp_a[4] = 12'd3616;
        exp_a[5] = 12'd3606;
        for (int k = 2; k <= 5; k++) begin
            if (obs_addr[k] !== exp_a[k]) begin
                $display("FAIL wrap_zero_tap%0d: got %0d want %0d", k - 2, obs_addr[k],
                         exp_a[k]);
                n_fail++;
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst            = 1'b1;
        sample_tick    = 1'b0;
        audio_left_in  = '0;
        audio_right_in = '0;
        tap_offsets    = '0;
        pre_we         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        test_reset();
        test_first_tick();
        test_offsets();
        test_overrun();
        test_reset_mid_read();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
